// File: rtl/edge_det_filt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : edge_det_filt
// Purpose  : Multi-channel edge detector for noisy asynchronous pins. Each
//            channel has a synchroniser, a programmable glitch filter, a
//            mode-qualified one-cycle event pulse and a sticky pending flag.
//            When EDGE_DET_FILT_CNT_EN is defined, each channel also has a
//            saturating event counter.
// Ports    : clk_i   - sampling clock
//            rst_i   - synchronous reset, active-high
//            dat_i   - raw asynchronous channel inputs
//            mode_i  - per channel [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both
//            filt_i  - filter threshold shared by all channels
//            clr_i   - per-channel clear of pending flag (and counter)
//            dat_o   - filtered, synchronised level
//            evt_o   - one-cycle qualified edge pulse
//            pend_o  - sticky pending flag
//            cnt_o   - per-channel event count (only with EDGE_DET_FILT_CNT_EN)
// Macro    : EDGE_DET_FILT_CNT_EN enables the per-channel event counters.
// Revision : 1.0 - initial release
// ============================================================================
module edge_det_filt #(
    parameter int CHN_NUM    = 4,
    parameter int STAGE      = 2,
    parameter int FILT_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [CHN_NUM-1:0]            dat_i,
    input  logic [2*CHN_NUM-1:0]          mode_i,
    input  logic [FILT_WIDTH-1:0]         filt_i,
    input  logic [CHN_NUM-1:0]            clr_i,
    output logic [CHN_NUM-1:0]            dat_o,
    output logic [CHN_NUM-1:0]            evt_o,
    output logic [CHN_NUM-1:0]            pend_o
`ifdef EDGE_DET_FILT_CNT_EN
    ,
    output logic [CHN_NUM*CNT_WIDTH-1:0]  cnt_o
`endif
);

    // Synchronised sample of every channel, input to the filters.
    logic [CHN_NUM-1:0] w_s;

    generate
        if (STAGE == 0) begin : g_nosync
            assign w_s = dat_i;
        end else begin : g_sync
            logic [CHN_NUM-1:0] r_sync [STAGE];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < STAGE; i++) begin
                        r_sync[i] <= '0;
                    end
                end else begin
                    r_sync[0] <= dat_i;
                    for (int i = 1; i < STAGE; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_s = r_sync[STAGE-1];
        end
    endgenerate

    genvar c;
    generate
        for (c = 0; c < CHN_NUM; c++) begin : g_chn
            logic [FILT_WIDTH-1:0] r_fcnt;
            logic                  r_dat;
            logic                  r_evt;
            logic                  r_pend;
            logic                  w_pass;
            logic                  w_qual;

            // The counter holds the number of earlier consecutive differing
            // samples; a threshold lowered below it passes on the next one.
            assign w_pass = (w_s[c] != r_dat) && (r_fcnt >= filt_i);

            // New level 1 is a rise (mode bit 0), new level 0 a fall (bit 1).
            assign w_qual = w_pass && (w_s[c] ? mode_i[2*c] : mode_i[2*c+1]);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_fcnt <= '0;
                    r_dat  <= 1'b0;
                    r_evt  <= 1'b0;
                    r_pend <= 1'b0;
                end else begin
                    if (w_s[c] == r_dat) begin
                        r_fcnt <= '0;
                    end else if (w_pass) begin
                        r_fcnt <= '0;
                        r_dat  <= w_s[c];
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                    r_evt  <= w_qual;
                    // A set on the same edge as a clear wins.
                    r_pend <= w_qual | (r_pend & ~clr_i[c]);
                end
            end

            assign dat_o[c]  = r_dat;
            assign evt_o[c]  = r_evt;
            assign pend_o[c] = r_pend;

`ifdef EDGE_DET_FILT_CNT_EN
            localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
            logic [CNT_WIDTH-1:0] r_cnt;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (clr_i[c]) begin
                    // Clear together with an event leaves exactly that event.
                    r_cnt <= CNT_WIDTH'(w_qual);
                end else if (w_qual && (r_cnt != c_cnt_max)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign cnt_o[c*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_edge_det_filt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_edge_det_filt
// Purpose  : Self-checking bench for edge_det_filt. Directed scenarios plus a
//            randomized run checked against a behavioural reference model
//            that tracks run lengths of differing samples per channel.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_det_filt;

    localparam int CHN  = 4;
    localparam int STG  = 2;
    localparam int FW   = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [CHN-1:0]    dat;
    logic [2*CHN-1:0]  mode;
    logic [FW-1:0]     filt;
    logic [CHN-1:0]    clr;
    logic [CHN-1:0]    dat_o;
    logic [CHN-1:0]    evt_o;
    logic [CHN-1:0]    pend_o;
    logic [CHN*CW-1:0] cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    edge_det_filt #(
        .CHN_NUM    (CHN),
        .STAGE      (STG),
        .FILT_WIDTH (FW),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .dat_i  (dat),
        .mode_i (mode),
        .filt_i (filt),
        .clr_i  (clr),
        .dat_o  (dat_o),
        .evt_o  (evt_o),
        .pend_o (pend_o)
`ifdef EDGE_DET_FILT_CNT_EN
        ,
        .cnt_o  (cnt_o)
`endif
    );

`ifndef EDGE_DET_FILT_CNT_EN
    assign cnt_o = '0;
`endif

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [CHN-1:0] m_q[$];     // dat_i history, oldest first
    logic [CHN-1:0] m_dout = '0;
    logic [CHN-1:0] m_evt  = '0;
    logic [CHN-1:0] m_pend = '0;
    int             m_run [CHN];
    int             m_cnt [CHN];

    task automatic model_edge();
        logic [CHN-1:0] s;
        logic [1:0]     md;
        bit             pass;
        bit             q;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < STG; i++) m_q.push_back('0);
            m_dout = '0;
            m_evt  = '0;
            m_pend = '0;
            for (int i = 0; i < CHN; i++) begin
                m_run[i] = 0;
                m_cnt[i] = 0;
            end
            return;
        end
        if (STG == 0) begin
            s = dat;
        end else begin
            s = m_q.pop_front();
            m_q.push_back(dat);
        end
        for (int i = 0; i < CHN; i++) begin
            pass = 1'b0;
            if (s[i] != m_dout[i]) begin
                // A new level is accepted after filt+1 consecutive samples.
                m_run[i] = m_run[i] + 1;
                if (m_run[i] > int'(filt)) begin
                    pass      = 1'b1;
                    m_run[i]  = 0;
                    m_dout[i] = s[i];
                end
            end else begin
                m_run[i] = 0;
            end
            md = mode[2*i +: 2];
            q  = pass && ((md == 2'b11) || (md == 2'b01 && s[i]) || (md == 2'b10 && !s[i]));
            m_evt[i] = q;
            if (q)           m_pend[i] = 1'b1;
            else if (clr[i]) m_pend[i] = 1'b0;
            if (clr[i])      m_cnt[i] = q ? 1 : 0;
            else if (q)      m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
        end
    endtask

    // One clock: model follows the same edge, outputs settle 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; dat = '0; clr = '0; mode = '0; filt = '0;
        step(); step();
        n_checks++;
        if (dat_o !== 4'h0) begin
            n_errors++; $display("FAIL reset_dat: got %h expected 0", dat_o);
        end
        n_checks++;
        if (evt_o !== 4'h0) begin
            n_errors++; $display("FAIL reset_evt: got %h expected 0", evt_o);
        end
        n_checks++;
        if (pend_o !== 4'h0) begin
            n_errors++; $display("FAIL reset_pend: got %h expected 0", pend_o);
        end
`ifdef EDGE_DET_FILT_CNT_EN
        n_checks++;
        if (cnt_o !== '0) begin
            n_errors++; $display("FAIL reset_cnt: got %h expected 0", cnt_o);
        end
`endif
    endtask

    task automatic test_level();
        bit e_lvl;
        rst = 1'b1; dat = 4'b0001; mode = 8'b00_00_00_01; filt = 4'd0;
        step(); step();
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            e_lvl = (k >= 3);
            n_checks++;
            if (evt_o[0] !== (k == 3)) begin
                n_errors++; $display("FAIL level_evt cyc %0d: got %b expected %b", k, evt_o[0], (k == 3));
            end
            n_checks++;
            if (dat_o[0] !== e_lvl) begin
                n_errors++; $display("FAIL level_dat cyc %0d: got %b expected %b", k, dat_o[0], e_lvl);
            end
            n_checks++;
            if (pend_o[0] !== e_lvl) begin
                n_errors++; $display("FAIL level_pend cyc %0d: got %b expected %b", k, pend_o[0], e_lvl);
            end
        end
        clr[0] = 1'b1;
        step();
        clr = '0;
        n_checks++;
        if (pend_o[0] !== 1'b0) begin
            n_errors++; $display("FAIL level_clr: got %b expected 0", pend_o[0]);
        end
    endtask

    task automatic test_glitch();
        int rise_at;
        int nevt;
        filt = 4'd3; mode = 8'b00_00_11_00; dat = '0; clr = '1;
        repeat (8) step();
        clr = '0;
        // 3-sample pulse: rejected entirely.
        for (int k = 0; k < 14; k++) begin
            dat[1] = (k < 3);
            step();
            n_checks++;
            if ({dat_o[1], evt_o[1], pend_o[1]} !== 3'b000) begin
                n_errors++;
                $display("FAIL glitch_reject cyc %0d: got dat/evt/pend %b%b%b expected 000", k, dat_o[1], evt_o[1], pend_o[1]);
            end
        end
        // 4-sample pulse: passes, rise and fall both reported in mode 11.
        rise_at = 0; nevt = 0;
        for (int k = 1; k <= 16; k++) begin
            dat[1] = (k <= 4);
            step();
            if (dat_o[1] === 1'b1 && rise_at == 0) rise_at = k;
            if (evt_o[1] === 1'b1) nevt++;
        end
        n_checks++;
        if (rise_at != STG + 4) begin
            n_errors++; $display("FAIL glitch_pass_latency: got %0d expected %0d", rise_at, STG + 4);
        end
        n_checks++;
        if (nevt != 2) begin
            n_errors++; $display("FAIL glitch_pass_events: got %0d expected 2", nevt);
        end
    endtask

    task automatic test_modes();
        int ev [CHN];
        int e_ev [CHN]  = '{0, 1, 1, 2};
        bit e_pd [CHN]  = '{0, 1, 1, 1};
        filt = 4'd0; mode = {2'b11, 2'b10, 2'b01, 2'b00}; dat = '0; clr = '1;
        repeat (6) step();
        clr = '0;
        for (int i = 0; i < CHN; i++) ev[i] = 0;
        for (int k = 0; k < 10; k++) begin
            dat = (k < 5) ? 4'hF : 4'h0;
            step();
            for (int i = 0; i < CHN; i++) if (evt_o[i] === 1'b1) ev[i]++;
            n_checks++;
            if (evt_o !== m_evt) begin
                n_errors++; $display("FAIL modes_evt_model cyc %0d: got %h expected %h", k, evt_o, m_evt);
            end
        end
        for (int i = 0; i < CHN; i++) begin
            n_checks++;
            if (ev[i] != e_ev[i]) begin
                n_errors++; $display("FAIL modes_count ch%0d: got %0d expected %0d", i, ev[i], e_ev[i]);
            end
            n_checks++;
            if (pend_o[i] !== e_pd[i]) begin
                n_errors++; $display("FAIL modes_pend ch%0d: got %b expected %b", i, pend_o[i], e_pd[i]);
            end
        end
    endtask

    task automatic test_race();
        filt = 4'd0; mode = 8'b00_01_00_00; dat = '0; clr = '1;
        repeat (4) step();
        clr = '0;
        dat[2] = 1'b1;
        step(); step();
        // Clear sampled on the same edge that registers the event.
        clr[2] = 1'b1;
        step();
        n_checks++;
        if (evt_o[2] !== 1'b1) begin
            n_errors++; $display("FAIL race_evt: got %b expected 1", evt_o[2]);
        end
        n_checks++;
        if (pend_o[2] !== 1'b1) begin
            n_errors++; $display("FAIL race_pend_set_wins: got %b expected 1", pend_o[2]);
        end
        step();
        clr = '0;
        n_checks++;
        if (pend_o[2] !== 1'b0) begin
            n_errors++; $display("FAIL race_pend_cleared: got %b expected 0", pend_o[2]);
        end
        step();
        n_checks++;
        if (pend_o[2] !== 1'b0) begin
            n_errors++; $display("FAIL race_pend_stays: got %b expected 0", pend_o[2]);
        end
    endtask

`ifdef EDGE_DET_FILT_CNT_EN
    task automatic test_counter();
        filt = 4'd0; mode = 8'b01_00_00_00; dat = '0; clr = '1;
        repeat (4) step();
        clr = '0;
        for (int e = 0; e < 5; e++) begin
            dat[3] = 1'b1; repeat (4) step();
            dat[3] = 1'b0; repeat (4) step();
        end
        n_checks++;
        if (cnt_o[3*CW +: CW] !== 2'd3) begin
            n_errors++; $display("FAIL counter_saturate: got %0d expected 3", cnt_o[3*CW +: CW]);
        end
        dat[3] = 1'b1;
        step(); step();
        clr[3] = 1'b1;
        step();
        clr = '0;
        n_checks++;
        if (evt_o[3] !== 1'b1) begin
            n_errors++; $display("FAIL counter_sixth_evt: got %b expected 1", evt_o[3]);
        end
        n_checks++;
        if (cnt_o[3*CW +: CW] !== 2'd1) begin
            n_errors++; $display("FAIL counter_clear_with_evt: got %0d expected 1", cnt_o[3*CW +: CW]);
        end
        dat[3] = 1'b0;
        repeat (4) step();
    endtask
`endif

    task automatic test_reset_mid();
        int rise_at;
        filt = 4'd7; mode = 8'b00_00_00_01; dat = '0; clr = '1;
        repeat (4) step();
        clr = '0;
        dat[0] = 1'b1;
        repeat (STG + 5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (dat_o !== 4'h0) begin
            n_errors++; $display("FAIL rstmid_dat: got %h expected 0", dat_o);
        end
        n_checks++;
        if (evt_o !== 4'h0) begin
            n_errors++; $display("FAIL rstmid_evt: got %h expected 0", evt_o);
        end
        rise_at = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (dat_o[0] === 1'b1 && rise_at == 0) begin
                rise_at = k;
                n_checks++;
                if (evt_o[0] !== 1'b1) begin
                    n_errors++; $display("FAIL rstmid_evt_on_rise: got %b expected 1", evt_o[0]);
                end
            end
        end
        n_checks++;
        if (rise_at != STG + 8) begin
            n_errors++; $display("FAIL rstmid_restart_latency: got %0d expected %0d", rise_at, STG + 8);
        end
    endtask

    task automatic test_random();
        int nprint = 0;
        dat = '0; clr = '0; rst = 1'b0; filt = 4'd1; mode = 8'hE4;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < CHN; i++) begin
                if ($urandom_range(0, 3) == 0) dat[i] = ~dat[i];
                clr[i] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 49) == 0)  filt = FW'($urandom_range(0, 5));
            if ($urandom_range(0, 99) == 0)  mode = 8'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            step();
            n_checks++;
            if (dat_o !== m_dout) begin
                n_errors++;
                if (nprint++ < 20) $display("FAIL rand_dat cyc %0d: got %h expected %h", k, dat_o, m_dout);
            end
            n_checks++;
            if (evt_o !== m_evt) begin
                n_errors++;
                if (nprint++ < 20) $display("FAIL rand_evt cyc %0d: got %h expected %h", k, evt_o, m_evt);
            end
            n_checks++;
            if (pend_o !== m_pend) begin
                n_errors++;
                if (nprint++ < 20) $display("FAIL rand_pend cyc %0d: got %h expected %h", k, pend_o, m_pend);
            end
`ifdef EDGE_DET_FILT_CNT_EN
            for (int i = 0; i < CHN; i++) begin
                n_checks++;
                if (cnt_o[i*CW +: CW] !== CW'(m_cnt[i])) begin
                    n_errors++;
                    if (nprint++ < 20) $display("FAIL rand_cnt ch%0d cyc %0d: got %0d expected %0d", i, k, cnt_o[i*CW +: CW], m_cnt[i]);
                end
            end
`endif
        end
        rst = 1'b0; clr = '0;
    endtask

    initial begin
        rst = 1'b1; dat = '0; clr = '0; mode = '0; filt = '0;
        test_reset();
        test_level();
        test_glitch();
        test_modes();
        test_race();
`ifdef EDGE_DET_FILT_CNT_EN
        test_counter();
`endif
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
